sprite_frame_mover: RTL and testbench

Consumer of the FPS down-counter value. Detects the one-cycle frame tick (counter == 0) and, once per frame, erases a rectangular sprite, steps its position by one pixel in x and y with edge bounce, and redraws it. Drives the VGA adapter pixel-write interface (x, y, colour, plot) directly.

---
 rtl/sprite_frame_mover.sv | 125 ++++++++++++
 tb/tb_sprite_frame_mover.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_frame_mover.sv
// Sprite frame mover: erases, steps and redraws a rectangular sprite
// once per FPS tick, driving the VGA adapter pixel-write port.
module sprite_frame_mover #(
  parameter int         SPRITE_W  = 4,
  parameter int         SPRITE_H  = 4,
  parameter int         SCREEN_W  = 160,
  parameter int         SCREEN_H  = 120,
  parameter int         X_INIT    = 0,
  parameter int         Y_INIT    = 0,
  parameter logic [2:0] FG_COLOUR = 3'b111,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [24:0] frame_counter,
  input  logic        enable,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  colour,
  output logic        plot,
  output logic        busy,
  output logic        frame_drop
);

  typedef enum logic [2:0] {
    INIT, IDLE, ERASE, UPDATE, DRAW
  } state_t;

  localparam logic [7:0] MAX_X   = 8'(SCREEN_W - SPRITE_W);
  localparam logic [6:0] MAX_Y   = 7'(SCREEN_H - SPRITE_H);
  localparam logic [3:0] OX_LAST = 4'(SPRITE_W - 1);
  localparam logic [3:0] OY_LAST = 4'(SPRITE_H - 1);

  state_t     state, state_n;
  logic [7:0] pos_x;
  logic [6:0] pos_y;
  logic       neg_x, neg_y;
  logic [3:0] ox, oy;
  logic       pending;
  logic       go;
  logic       last_px;

  assign go      = (frame_counter == '0) && enable;
  assign last_px = (ox == OX_LAST) && (oy == OY_LAST);

  // Next-state decode; also feeds the registered busy flag
  always_comb begin
    state_n = state;
    unique case (state)
      INIT:    state_n = DRAW;
      IDLE:    if (go || pending) state_n = ERASE;
      ERASE:   if (last_px) state_n = UPDATE;
      UPDATE:  state_n = DRAW;
      DRAW:    if (last_px) state_n = IDLE;
      default: state_n = INIT;
    endcase
  end

  // FSM, tick queueing, pixel walk, position update, registered outputs
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= INIT;
      pos_x      <= 8'(X_INIT);
      pos_y      <= 7'(Y_INIT);
      neg_x      <= 1'b0;
      neg_y      <= 1'b0;
      ox         <= '0;
      oy         <= '0;
      pending    <= 1'b0;
      x          <= '0;
      y          <= '0;
      colour     <= '0;
      plot       <= 1'b0;
      busy       <= 1'b0;
      frame_drop <= 1'b0;
    end else begin
      state      <= state_n;
      busy       <= (state_n != IDLE);
      frame_drop <= 1'b0;
      plot       <= 1'b0;

      if (state == IDLE) begin
        pending <= 1'b0;
      end else if (go) begin
        pending <= 1'b1;
        if (pending) frame_drop <= 1'b1;
      end

      if (state == ERASE || state == DRAW) begin
        x      <= pos_x + {4'b0, ox};
        y      <= pos_y + {3'b0, oy};
        colour <= (state == ERASE) ? BG_COLOUR : FG_COLOUR;
        plot   <= 1'b1;
        if (ox == OX_LAST) begin
          ox <= '0;
          oy <= (oy == OY_LAST) ? 4'd0 : oy + 4'd1;
        end else begin
          ox <= ox + 4'd1;
        end
      end

      if (state == UPDATE) begin
        if (!neg_x && pos_x == MAX_X) begin
          neg_x <= 1'b1;
          pos_x <= MAX_X - 8'd1;
        end else if (neg_x && pos_x == '0) begin
          neg_x <= 1'b0;
          pos_x <= 8'd1;
        end else begin
          pos_x <= neg_x ? pos_x - 8'd1 : pos_x + 8'd1;
        end
        if (!neg_y && pos_y == MAX_Y) begin
          neg_y <= 1'b1;
          pos_y <= MAX_Y - 7'd1;
        end else if (neg_y && pos_y == '0) begin
          neg_y <= 1'b0;
          pos_y <= 7'd1;
        end else begin
          pos_y <= neg_y ? pos_y - 7'd1 : pos_y + 7'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sprite_frame_mover.sv
// Directed bench for sprite_frame_mover: init draw, frame passes,
// edge bounce, enable gating, tick overrun and mid-pass reset.
module tb_sprite_frame_mover;

  logic        clock = 1'b0;
  logic        resetn;
  logic        enable;
  logic [24:0] fc [3];
  logic [7:0]  xs [3];
  logic [6:0]  ys [3];
  logic [2:0]  cs [3];
  logic        pl [3];
  logic        bz [3];
  logic        fd [3];

  int checks   = 0;
  int failures = 0;
  int bcnt     = 0;
  int pcnt     = 0;
  int dcnt     = 0;

  always #5 clock = ~clock;

  sprite_frame_mover u0 (
    .clock(clock), .resetn(resetn), .frame_counter(fc[0]),
    .enable(enable), .x(xs[0]), .y(ys[0]), .colour(cs[0]),
    .plot(pl[0]), .busy(bz[0]), .frame_drop(fd[0])
  );

  sprite_frame_mover #(.X_INIT(156), .Y_INIT(116)) u1 (
    .clock(clock), .resetn(resetn), .frame_counter(fc[1]),
    .enable(enable), .x(xs[1]), .y(ys[1]), .colour(cs[1]),
    .plot(pl[1]), .busy(bz[1]), .frame_drop(fd[1])
  );

  sprite_frame_mover #(
    .SCREEN_W(5), .SCREEN_H(5), .X_INIT(1), .Y_INIT(1)
  ) u2 (
    .clock(clock), .resetn(resetn), .frame_counter(fc[2]),
    .enable(enable), .x(xs[2]), .y(ys[2]), .colour(cs[2]),
    .plot(pl[2]), .busy(bz[2]), .frame_drop(fd[2])
  );

  // plot and frame_drop event counters for the main instance
  always @(negedge clock) begin
    if (pl[0]) pcnt <= pcnt + 1;
    if (fd[0]) dcnt <= dcnt + 1;
  end

  typedef struct {
    int   u;
    logic en;
    logic act;
    int   ex, ey, dx, dy;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input bit ok, input string nm,
                     input string act, input string exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %s, want %s", nm, act, exp);
    end
  endtask

  task automatic check_block(input int u, input logic [2:0] col,
                             input int bx, input int by,
                             input string nm);
    for (int i = 0; i < 16; i++) begin
      int ex;
      int ey;
      ex = bx + i % 4;
      ey = by + i / 4;
      chk(pl[u] === 1'b1 && xs[u] == 8'(ex) && ys[u] == 7'(ey)
          && cs[u] == col,
          $sformatf("%s px%0d", nm, i),
          $sformatf("plot=%b x=%0d y=%0d c=%0d",
                    pl[u], xs[u], ys[u], cs[u]),
          $sformatf("plot=1 x=%0d y=%0d c=%0d", ex, ey, col));
      if (bz[u]) bcnt++;
      @(negedge clock);
    end
  endtask

  task automatic tick(input int u);
    fc[u] = 25'd0;
    @(negedge clock);
    fc[u] = 25'd5;
  endtask

  task automatic do_pass(input int u, input int ex, input int ey,
                         input int dx, input int dy,
                         input string nm);
    bcnt = 0;
    tick(u);
    chk(bz[u] === 1'b1 && pl[u] === 1'b0, {nm, " start"},
        $sformatf("busy=%b plot=%b", bz[u], pl[u]), "busy=1 plot=0");
    if (bz[u]) bcnt++;
    @(negedge clock);
    check_block(u, 3'b000, ex, ey, {nm, " erase"});
    chk(pl[u] === 1'b0, {nm, " gap"},
        $sformatf("plot=%b", pl[u]), "plot=0");
    if (bz[u]) bcnt++;
    @(negedge clock);
    check_block(u, 3'b111, dx, dy, {nm, " draw"});
    chk(pl[u] === 1'b0 && bz[u] === 1'b0 && bcnt == 33, {nm, " end"},
        $sformatf("plot=%b busy=%b busy_cycles=%0d", pl[u], bz[u], bcnt),
        "plot=0 busy=0 busy_cycles=33");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int d0;
    logic seen;

    vecs[0] = '{0, 1'b1, 1'b1, 0, 0, 1, 1};
    vecs[1] = '{0, 1'b0, 1'b0, 0, 0, 0, 0};
    vecs[2] = '{0, 1'b1, 1'b1, 1, 1, 2, 2};
    vecs[3] = '{0, 1'b1, 1'b1, 2, 2, 3, 3};
    vecs[4] = '{1, 1'b1, 1'b1, 156, 116, 155, 115};
    vecs[5] = '{1, 1'b1, 1'b1, 155, 115, 154, 114};
    vecs[6] = '{2, 1'b1, 1'b1, 1, 1, 0, 0};
    vecs[7] = '{2, 1'b1, 1'b1, 0, 0, 1, 1};

    resetn = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 3; i++) fc[i] = 25'd5;
    #3 resetn = 1'b0;
    repeat (3) @(negedge clock);
    chk(xs[0] == 8'd0 && ys[0] == 7'd0 && cs[0] == 3'd0 &&
        pl[0] === 1'b0 && bz[0] === 1'b0 && fd[0] === 1'b0,
        "reset state",
        $sformatf("x=%0d y=%0d c=%0d plot=%b busy=%b drop=%b",
                  xs[0], ys[0], cs[0], pl[0], bz[0], fd[0]),
        "all zero");

    resetn = 1'b1;
    @(negedge clock);
    chk(bz[0] === 1'b1 && pl[0] === 1'b0, "init start",
        $sformatf("busy=%b plot=%b", bz[0], pl[0]), "busy=1 plot=0");
    @(negedge clock);
    check_block(0, 3'b111, 0, 0, "init");
    chk(pl[0] === 1'b0 && bz[0] === 1'b0, "init end",
        $sformatf("plot=%b busy=%b", pl[0], bz[0]), "plot=0 busy=0");
    repeat (3) @(negedge clock);

    for (int v = 0; v < 8; v++) begin
      if (vecs[v].act) begin
        enable = vecs[v].en;
        do_pass(vecs[v].u, vecs[v].ex, vecs[v].ey,
                vecs[v].dx, vecs[v].dy, $sformatf("vec%0d", v));
      end else begin
        enable = vecs[v].en;
        tick(vecs[v].u);
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
          if (pl[vecs[v].u] !== 1'b0 || bz[vecs[v].u] !== 1'b0)
            seen = 1'b1;
          @(negedge clock);
        end
        chk(!seen, $sformatf("vec%0d disabled", v),
            $sformatf("activity=%b", seen), "activity=0");
        enable = 1'b1;
      end
      @(negedge clock);
    end

    p0 = pcnt;
    d0 = dcnt;
    tick(0);
    @(negedge clock);
    fc[0] = 25'd0;
    @(negedge clock);
    fc[0] = 25'd5;
    @(negedge clock);
    fc[0] = 25'd0;
    @(negedge clock);
    fc[0] = 25'd5;
    chk(fd[0] === 1'b1, "drop pulse",
        $sformatf("drop=%b", fd[0]), "drop=1");
    @(negedge clock);
    chk(fd[0] === 1'b0, "drop width",
        $sformatf("drop=%b", fd[0]), "drop=0");
    repeat (80) @(negedge clock);
    chk(pcnt - p0 == 64 && dcnt - d0 == 1, "overrun passes",
        $sformatf("plots=%0d drops=%0d", pcnt - p0, dcnt - d0),
        "plots=64 drops=1");

    do_pass(0, 5, 5, 6, 6, "after overrun");
    @(negedge clock);

    p0 = pcnt;
    d0 = dcnt;
    tick(0);
    repeat (32) @(negedge clock);
    fc[0] = 25'd0;
    @(negedge clock);
    fc[0] = 25'd5;
    chk(pl[0] === 1'b1 && cs[0] == 3'b111 && xs[0] == 8'd10,
        "last draw px",
        $sformatf("plot=%b c=%0d x=%0d", pl[0], cs[0], xs[0]),
        "plot=1 c=7 x=10");
    @(negedge clock);
    chk(pl[0] === 1'b0 && bz[0] === 1'b1, "pending idle cycle",
        $sformatf("plot=%b busy=%b", pl[0], bz[0]), "plot=0 busy=1");
    @(negedge clock);
    chk(pl[0] === 1'b1 && cs[0] == 3'b000 && xs[0] == 8'd7,
        "pending erase start",
        $sformatf("plot=%b c=%0d x=%0d", pl[0], cs[0], xs[0]),
        "plot=1 c=0 x=7");
    repeat (70) @(negedge clock);
    chk(pcnt - p0 == 64 && dcnt - d0 == 0, "last draw tick",
        $sformatf("plots=%0d drops=%0d", pcnt - p0, dcnt - d0),
        "plots=64 drops=0");

    tick(0);
    @(negedge clock);
    repeat (16) @(negedge clock);
    @(negedge clock);
    repeat (7) @(negedge clock);
    chk(pl[0] === 1'b1 && xs[0] == 8'd12 && ys[0] == 7'd10,
        "pre-reset px7",
        $sformatf("plot=%b x=%0d y=%0d", pl[0], xs[0], ys[0]),
        "plot=1 x=12 y=10");
    #2 resetn = 1'b0;
    #1;
    chk(pl[0] === 1'b0 && bz[0] === 1'b0 && xs[0] == 8'd0,
        "async abort",
        $sformatf("plot=%b busy=%b x=%0d", pl[0], bz[0], xs[0]),
        "plot=0 busy=0 x=0");
    @(negedge clock);
    p0 = pcnt;
    resetn = 1'b1;
    @(negedge clock);
    chk(bz[0] === 1'b1 && pl[0] === 1'b0, "reinit start",
        $sformatf("busy=%b plot=%b", bz[0], pl[0]), "busy=1 plot=0");
    @(negedge clock);
    check_block(0, 3'b111, 0, 0, "reinit");
    repeat (40) @(negedge clock);
    chk(pcnt - p0 == 16 && bz[0] === 1'b0, "reinit only",
        $sformatf("plots=%0d busy=%b", pcnt - p0, bz[0]),
        "plots=16 busy=0");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
